// File: rtl/uart_lite_pkg.sv
// Shared definitions for the UART-Lite AXI4-lite responder.
// Contents: register address enums, STAT/CTRL bit positions,
// AXI response codes and the read/write FSM state types.
package uart_lite_pkg;

    typedef enum logic [3:0] {
        RX_FIFO  = 4'h0,
        STAT_REG = 4'h8
    } raddr_type;

    typedef enum logic [3:0] {
        TX_FIFO  = 4'h4,
        CTRL_REG = 4'hC
    } waddr_type;

    localparam int STAT_RX_VALID = 0;
    localparam int STAT_RX_FULL  = 1;
    localparam int STAT_TX_EMPTY = 2;
    localparam int STAT_TX_FULL  = 3;
    localparam int STAT_INTR_EN  = 4;
    localparam int STAT_OVERRUN  = 5;

    localparam int CTRL_TX_CLR   = 0;
    localparam int CTRL_RX_CLR   = 1;
    localparam int CTRL_INTR_SET = 4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic { W_IDLE, W_RESP } wstate_t;
    typedef enum logic { R_IDLE, R_DATA } rstate_t;

endpackage

// File: rtl/byte_fifo.sv
// Synchronous byte FIFO with push, pop and clear.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   push, din    enqueue a byte (taken when not full, or full with a pop)
//   pop          dequeue the head (ignored when empty)
//   clear        empties the FIFO; wins over a same-cycle push/pop
//   dout         head entry (valid when !empty)
//   full, empty  occupancy flags
module byte_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic       clear,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    logic [7:0]  r_mem [DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic        w_do_push;
    logic        w_do_pop;

    // Pointers carry one extra bit: equal low bits with differing MSBs means full.
    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    // A pop on a full FIFO frees the slot the same-cycle push lands in.
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);
    assign dout      = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // NOTE: storage has no reset; the pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_lite_responder.sv
// AXI4-lite slave with the 4-register UART-Lite map, backed by an RX and a TX
// byte FIFO. Host bytes arrive on rx_t*, CPU-written TX bytes leave on tx_t*.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   uart_axi_ar*/r*           read address / read data channels
//   uart_axi_aw*/w*/b*        write address / data / response channels
//   rx_tdata/tvalid/tready    inbound byte stream (into RX FIFO)
//   tx_tdata/tvalid/tready    outbound byte stream (head of TX FIFO)
module uart_lite_responder
    import uart_lite_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int FIFO_AW    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  uart_axi_araddr,
    input  logic        uart_axi_arvalid,
    output logic        uart_axi_arready,
    output logic [31:0] uart_axi_rdata,
    output logic [1:0]  uart_axi_rresp,
    output logic        uart_axi_rvalid,
    input  logic        uart_axi_rready,
    input  logic [3:0]  uart_axi_awaddr,
    input  logic        uart_axi_awvalid,
    output logic        uart_axi_awready,
    input  logic [31:0] uart_axi_wdata,
    input  logic [3:0]  uart_axi_wstrb,
    input  logic        uart_axi_wvalid,
    output logic        uart_axi_wready,
    output logic [1:0]  uart_axi_bresp,
    output logic        uart_axi_bvalid,
    input  logic        uart_axi_bready,
    input  logic [7:0]  rx_tdata,
    input  logic        rx_tvalid,
    output logic        rx_tready,
    output logic [7:0]  tx_tdata,
    output logic        tx_tvalid,
    input  logic        tx_tready
);

    wstate_t    r_wstate, w_wstate_nxt;
    rstate_t    r_rstate, w_rstate_nxt;
    logic [1:0] r_bresp, w_bresp_nxt;
    logic [7:0] r_rdata, w_rdata_nxt;
    logic       r_overrun;
    logic       r_intr_en;

    logic       w_tx_push, w_tx_clear, w_rx_clear, w_intr_set;
    logic       w_rx_pop, w_stat_rd;
    logic       w_rx_full, w_rx_empty, w_tx_full, w_tx_empty;
    logic [7:0] w_rx_dout;
    logic [7:0] w_stat;

    // Byte lanes above [7:0] and the strobes carry no meaning here.
    logic       w_unused;
    assign w_unused = ^{uart_axi_wstrb, uart_axi_wdata[31:8]};

    byte_fifo #(.DEPTH(FIFO_DEPTH), .AW(FIFO_AW)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_tvalid && rx_tready),
        .pop   (w_rx_pop),
        .clear (w_rx_clear),
        .din   (rx_tdata),
        .dout  (w_rx_dout),
        .full  (w_rx_full),
        .empty (w_rx_empty)
    );

    byte_fifo #(.DEPTH(FIFO_DEPTH), .AW(FIFO_AW)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_tx_push),
        .pop   (tx_tvalid && tx_tready),
        .clear (w_tx_clear),
        .din   (uart_axi_wdata[7:0]),
        .dout  (tx_tdata),
        .full  (w_tx_full),
        .empty (w_tx_empty)
    );

    assign rx_tready = !w_rx_full;
    assign tx_tvalid = !w_tx_empty;

    always_comb begin
        w_stat                = '0;
        w_stat[STAT_RX_VALID] = !w_rx_empty;
        w_stat[STAT_RX_FULL]  = w_rx_full;
        w_stat[STAT_TX_EMPTY] = w_tx_empty;
        w_stat[STAT_TX_FULL]  = w_tx_full;
        w_stat[STAT_INTR_EN]  = r_intr_en;
        w_stat[STAT_OVERRUN]  = r_overrun;
    end

    // Write channel: address and data are only ever taken together.
    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        w_wstate_nxt     = r_wstate;
        w_bresp_nxt      = r_bresp;
        uart_axi_awready = 1'b0;
        uart_axi_wready  = 1'b0;
        w_tx_push        = 1'b0;
        w_tx_clear       = 1'b0;
        w_rx_clear       = 1'b0;
        w_intr_set       = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                if (uart_axi_awvalid && uart_axi_wvalid && !rst) begin
                    uart_axi_awready = 1'b1;
                    uart_axi_wready  = 1'b1;
                    w_wstate_nxt     = W_RESP;
                    w_bresp_nxt      = RESP_SLVERR;
                    case (uart_axi_awaddr)
                        TX_FIFO: begin
                            w_tx_push   = 1'b1;
                            w_bresp_nxt = RESP_OKAY;
                        end
                        CTRL_REG: begin
                            w_tx_clear  = uart_axi_wdata[CTRL_TX_CLR];
                            w_rx_clear  = uart_axi_wdata[CTRL_RX_CLR];
                            w_intr_set  = uart_axi_wdata[CTRL_INTR_SET];
                            w_bresp_nxt = RESP_OKAY;
                        end
                        default: ;
                    endcase
                end
            end
            W_RESP:  if (uart_axi_bready) w_wstate_nxt = W_IDLE;
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    // Read channel: data is captured at address acceptance and held until rready.
    always_comb begin
        w_rstate_nxt     = r_rstate;
        w_rdata_nxt      = r_rdata;
        uart_axi_arready = 1'b0;
        w_rx_pop         = 1'b0;
        w_stat_rd        = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                if (uart_axi_arvalid && !rst) begin
                    uart_axi_arready = 1'b1;
                    w_rstate_nxt     = R_DATA;
                    w_rdata_nxt      = '0;
                    case (uart_axi_araddr)
                        RX_FIFO: begin
                            w_rx_pop    = !w_rx_empty;
                            w_rdata_nxt = w_rx_empty ? 8'h00 : w_rx_dout;
                        end
                        STAT_REG: begin
                            w_stat_rd   = 1'b1;
                            w_rdata_nxt = w_stat;
                        end
                        default: ;
                    endcase
                end
            end
            R_DATA:  if (uart_axi_rready) w_rstate_nxt = R_IDLE;
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wstate  <= W_IDLE;
            r_rstate  <= R_IDLE;
            r_bresp   <= RESP_OKAY;
            r_rdata   <= '0;
            r_overrun <= 1'b0;
            r_intr_en <= 1'b0;
        end else begin
            r_wstate <= w_wstate_nxt;
            r_rstate <= w_rstate_nxt;
            r_bresp  <= w_bresp_nxt;
            r_rdata  <= w_rdata_nxt;
            if (w_intr_set) r_intr_en <= 1'b1;
            // A refused byte sets overrun unless a CPU pop is freeing space this cycle;
            // a fresh overrun outranks the clear-on-STAT-read of the old value.
            if (w_rx_clear)                                r_overrun <= 1'b0;
            else if (rx_tvalid && w_rx_full && !w_rx_pop)  r_overrun <= 1'b1;
            else if (w_stat_rd)                            r_overrun <= 1'b0;
        end
    end

    assign uart_axi_bvalid = (r_wstate == W_RESP);
    assign uart_axi_bresp  = r_bresp;
    assign uart_axi_rvalid = (r_rstate == R_DATA);
    assign uart_axi_rdata  = {24'h0, r_rdata};
    assign uart_axi_rresp  = RESP_OKAY;

endmodule

// File: tb/tb_uart_lite_responder.sv
// Self-checking bench for uart_lite_responder: directed scenarios followed by a
// randomized mix, all checked against a queue-based model of the register map.
module tb_uart_lite_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  uart_axi_araddr = '0;
    logic        uart_axi_arvalid = 1'b0;
    logic        uart_axi_arready;
    logic [31:0] uart_axi_rdata;
    logic [1:0]  uart_axi_rresp;
    logic        uart_axi_rvalid;
    logic        uart_axi_rready = 1'b0;
    logic [3:0]  uart_axi_awaddr = '0;
    logic        uart_axi_awvalid = 1'b0;
    logic        uart_axi_awready;
    logic [31:0] uart_axi_wdata = '0;
    logic [3:0]  uart_axi_wstrb = '0;
    logic        uart_axi_wvalid = 1'b0;
    logic        uart_axi_wready;
    logic [1:0]  uart_axi_bresp;
    logic        uart_axi_bvalid;
    logic        uart_axi_bready = 1'b0;
    logic [7:0]  rx_tdata = '0;
    logic        rx_tvalid = 1'b0;
    logic        rx_tready;
    logic [7:0]  tx_tdata;
    logic        tx_tvalid;
    logic        tx_tready = 1'b0;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: plain queues and flags.
    localparam int DEPTH = 16;
    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];
    logic       m_overrun = 1'b0;
    logic       m_intr_en = 1'b0;

    uart_lite_responder dut (
        .clk              (clk),
        .rst              (rst),
        .uart_axi_araddr  (uart_axi_araddr),
        .uart_axi_arvalid (uart_axi_arvalid),
        .uart_axi_arready (uart_axi_arready),
        .uart_axi_rdata   (uart_axi_rdata),
        .uart_axi_rresp   (uart_axi_rresp),
        .uart_axi_rvalid  (uart_axi_rvalid),
        .uart_axi_rready  (uart_axi_rready),
        .uart_axi_awaddr  (uart_axi_awaddr),
        .uart_axi_awvalid (uart_axi_awvalid),
        .uart_axi_awready (uart_axi_awready),
        .uart_axi_wdata   (uart_axi_wdata),
        .uart_axi_wstrb   (uart_axi_wstrb),
        .uart_axi_wvalid  (uart_axi_wvalid),
        .uart_axi_wready  (uart_axi_wready),
        .uart_axi_bresp   (uart_axi_bresp),
        .uart_axi_bvalid  (uart_axi_bvalid),
        .uart_axi_bready  (uart_axi_bready),
        .rx_tdata         (rx_tdata),
        .rx_tvalid        (rx_tvalid),
        .rx_tready        (rx_tready),
        .tx_tdata         (tx_tdata),
        .tx_tvalid        (tx_tvalid),
        .tx_tready        (tx_tready)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_stat();
        logic [31:0] s;
        s    = '0;
        s[0] = (rx_q.size() != 0);
        s[1] = (rx_q.size() == DEPTH);
        s[2] = (tx_q.size() == 0);
        s[3] = (tx_q.size() == DEPTH);
        s[4] = m_intr_en;
        s[5] = m_overrun;
        return s;
    endfunction

    function automatic logic [31:0] model_read(input logic [3:0] a);
        logic [31:0] v;
        v = '0;
        if (a == 4'h0) begin
            if (rx_q.size() != 0) v = {24'h0, rx_q.pop_front()};
        end else if (a == 4'h8) begin
            v = model_stat();
            m_overrun = 1'b0;
        end
        return v;
    endfunction

    function automatic logic [1:0] model_write(input logic [3:0] a, input logic [31:0] d);
        if (a == 4'h4) begin
            if (tx_q.size() < DEPTH) tx_q.push_back(d[7:0]);
            return 2'b00;
        end
        if (a == 4'hC) begin
            if (d[0]) tx_q.delete();
            if (d[1]) begin rx_q.delete(); m_overrun = 1'b0; end
            if (d[4]) m_intr_en = 1'b1;
            return 2'b00;
        end
        return 2'b10;
    endfunction

    task automatic axi_read(input logic [3:0] a);
        logic [31:0] exp_d;
        int t;
        @(negedge clk);
        uart_axi_araddr  = a;
        uart_axi_arvalid = 1'b1;
        #1;
        t = 0;
        while (uart_axi_arready !== 1'b1 && t < 16) begin
            @(negedge clk); #1; t++;
        end
        check("ar_accept", 32'(t < 16), 32'd1);
        exp_d = model_read(a);
        @(negedge clk);
        check("arready_pulse", 32'(uart_axi_arready), 32'd0);
        uart_axi_arvalid = 1'b0;
        check("rvalid_latency", 32'(uart_axi_rvalid), 32'd1);
        check($sformatf("rdata_%0h", a), uart_axi_rdata, exp_d);
        check("rresp", 32'(uart_axi_rresp), 32'd0);
        repeat ($urandom_range(0, 2)) begin
            @(negedge clk);
            check("rvalid_hold", 32'(uart_axi_rvalid), 32'd1);
            check("rdata_hold", uart_axi_rdata, exp_d);
        end
        uart_axi_rready = 1'b1;
        @(negedge clk);
        uart_axi_rready = 1'b0;
        check("rvalid_drop", 32'(uart_axi_rvalid), 32'd0);
    endtask

    task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input int hold);
        logic [1:0] exp_r;
        int t;
        @(negedge clk);
        uart_axi_awaddr  = a;
        uart_axi_wdata   = d;
        uart_axi_wstrb   = 4'($urandom);
        uart_axi_awvalid = 1'b1;
        uart_axi_wvalid  = 1'b1;
        #1;
        t = 0;
        while (!(uart_axi_awready === 1'b1 && uart_axi_wready === 1'b1) && t < 16) begin
            @(negedge clk); #1; t++;
        end
        check("aw_w_accept", 32'(t < 16), 32'd1);
        exp_r = model_write(a, d);
        @(negedge clk);
        check("awready_pulse", 32'(uart_axi_awready), 32'd0);
        uart_axi_awvalid = 1'b0;
        uart_axi_wvalid  = 1'b0;
        check("bvalid", 32'(uart_axi_bvalid), 32'd1);
        check($sformatf("bresp_%0h", a), 32'(uart_axi_bresp), 32'(exp_r));
        repeat (hold) begin
            @(negedge clk);
            check("bvalid_hold", 32'(uart_axi_bvalid), 32'd1);
            check("bresp_hold", 32'(uart_axi_bresp), 32'(exp_r));
        end
        uart_axi_bready = 1'b1;
        @(negedge clk);
        uart_axi_bready = 1'b0;
        check("bvalid_drop", 32'(uart_axi_bvalid), 32'd0);
    endtask

    task automatic rx_send(input logic [7:0] b);
        @(negedge clk);
        rx_tdata  = b;
        rx_tvalid = 1'b1;
        #1;
        check("rx_tready", 32'(rx_tready), 32'(rx_q.size() < DEPTH));
        if (rx_q.size() < DEPTH) rx_q.push_back(b);
        else                     m_overrun = 1'b1;
        @(negedge clk);
        rx_tvalid = 1'b0;
    endtask

    task automatic tx_drain(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            tx_tready = 1'b1;
            check("tx_tvalid", 32'(tx_tvalid), 32'(tx_q.size() != 0));
            if (tx_q.size() != 0) begin
                check("tx_tdata", 32'(tx_tdata), 32'(tx_q[0]));
                void'(tx_q.pop_front());
            end
        end
        @(negedge clk);
        tx_tready = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        logic [3:0]  a;

        // 1. reset state and first STAT read
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_arready", 32'(uart_axi_arready), 32'd0);
        check("rst_awready", 32'(uart_axi_awready), 32'd0);
        check("rst_rvalid",  32'(uart_axi_rvalid),  32'd0);
        check("rst_bvalid",  32'(uart_axi_bvalid),  32'd0);
        check("rst_tx_tvalid", 32'(tx_tvalid), 32'd0);
        check("rst_rx_tready", 32'(rx_tready), 32'd1);
        axi_read(4'h8);

        // 2. one host byte through RX
        rx_send(8'h41);
        axi_read(4'h8);
        axi_read(4'h0);
        axi_read(4'h8);

        // 3. single TX byte, response held before bready
        axi_write(4'h4, 32'h0000_005A, 3);
        tx_drain(2);

        // address or data alone is never accepted
        @(negedge clk);
        uart_axi_awaddr = 4'h4; uart_axi_awvalid = 1'b1; #1;
        check("aw_alone", 32'({uart_axi_awready, uart_axi_wready}), 32'd0);
        @(negedge clk);
        uart_axi_awvalid = 1'b0; uart_axi_wvalid = 1'b1; #1;
        check("w_alone", 32'({uart_axi_awready, uart_axi_wready}), 32'd0);
        @(negedge clk);
        uart_axi_wvalid = 1'b0;
        check("alone_no_bvalid", 32'(uart_axi_bvalid), 32'd0);

        // 4. overfill TX: 17th byte dropped, stream yields the first 16
        for (int i = 0; i < 17; i++) axi_write(4'h4, $urandom, 0);
        axi_read(4'h8);
        tx_drain(17);

        // 5. fill RX, hold two extra cycles, overrun; one TX byte pending
        axi_write(4'h4, $urandom, 0);
        for (int i = 0; i < 18; i++) rx_send(8'($urandom));
        axi_read(4'h8);
        axi_read(4'h8);
        axi_write(4'hC, 32'h0000_0002, 1);
        axi_read(4'h8);
        axi_read(4'h0);
        axi_read(4'h4);
        axi_read(4'hC);
        axi_write(4'h0, $urandom, 0);
        axi_write(4'hC, 32'h0000_0010, 0);
        axi_read(4'h8);

        // randomized mix against the model
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 7))
                0, 1: rx_send(8'($urandom));
                2:    axi_read(4'h0);
                3:    axi_read(4'h8);
                4:    axi_write(4'h4, $urandom, $urandom_range(0, 2));
                5:    tx_drain($urandom_range(1, 4));
                6: begin
                    d = $urandom;
                    if ($urandom_range(0, 3) != 0) d[1:0] = 2'b00;
                    axi_write(4'hC, d, 0);
                end
                default: begin
                    a = 4'($urandom_range(0, 15));
                    if ($urandom_range(0, 1) == 0) axi_read(a);
                    else                           axi_write(a, $urandom, 0);
                end
            endcase
        end
        axi_read(4'h8);

        // 6. SLVERR held with bready low, then reset drops the response
        @(negedge clk);
        uart_axi_awaddr = 4'h8; uart_axi_wdata = $urandom;
        uart_axi_awvalid = 1'b1; uart_axi_wvalid = 1'b1;
        @(negedge clk);
        uart_axi_awvalid = 1'b0; uart_axi_wvalid = 1'b0;
        check("slverr_bvalid", 32'(uart_axi_bvalid), 32'd1);
        check("slverr_bresp",  32'(uart_axi_bresp),  32'd2);
        repeat (5) begin
            @(negedge clk);
            check("slverr_bvalid_hold", 32'(uart_axi_bvalid), 32'd1);
            check("slverr_bresp_hold",  32'(uart_axi_bresp),  32'd2);
        end
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_bvalid", 32'(uart_axi_bvalid), 32'd0);
        check("rst_mid_bresp",  32'(uart_axi_bresp),  32'd0);
        rst = 1'b0;
        rx_q.delete();
        tx_q.delete();
        m_overrun = 1'b0;
        m_intr_en = 1'b0;
        axi_read(4'h8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
